// File: rtl/dmem_dual_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_dual_arbiter
//
// Shares one single-cycle data-memory port between two MEM-stage lanes
// (alpha and beta). A lone request goes straight through with no added
// latency. When both lanes request in the same cycle, alpha is served
// first while the pipeline is stalled for one cycle. Alpha's read data is
// captured into alp_buf, and beta is served in the following cycle.
// Alpha-first ordering keeps same-address store/load pairs in program order.
//
// Optional feature macro: DMEM_ARB_PERF_CNT_EN
//   defined   -> conflict_cnt is a saturating 32-bit count of conflicts
//   undefined -> conflict_cnt is tied to 0 and no counter flops are built
//
// Ports
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   mreq_/write_/addr_/wdata_/size_{alp,bta}   lane requests
//   mem_rdata                 read data from the memory port (same cycle)
//   mem_mreq/write/addr/wdata/size             request to the memory port
//   rdata_alp, rdata_bta      load data returned to each lane
//   gnt_alp, gnt_bta          lane currently driving the memory port
//   stall                     freezes IF..MEM pipeline registers for a cycle
//   conflict_cnt              dual-request conflict counter
// -----------------------------------------------------------------------------
module dmem_dual_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        mreq_alp,
  input  logic        mreq_bta,
  input  logic        write_alp,
  input  logic        write_bta,
  input  logic [31:0] addr_alp,
  input  logic [31:0] addr_bta,
  input  logic [31:0] wdata_alp,
  input  logic [31:0] wdata_bta,
  input  logic [1:0]  size_alp,
  input  logic [1:0]  size_bta,
  input  logic [31:0] mem_rdata,
  output logic        mem_mreq,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_size,
  output logic [31:0] rdata_alp,
  output logic [31:0] rdata_bta,
  output logic        gnt_alp,
  output logic        gnt_bta,
  output logic        stall,
  output logic [31:0] conflict_cnt
);

  typedef enum logic {
    IDLE      = 1'b0,
    SERVE_BTA = 1'b1
  } state_e;

  state_e      state_q, state_d;
  state_e      cur_state;
  logic [31:0] alp_buf_q;
  logic        conflict;

  // While reset is held the outputs behave as in IDLE on the live inputs.
  assign cur_state = rst ? IDLE : state_q;

  always_comb begin
    state_d   = IDLE;
    conflict  = 1'b0;
    mem_mreq  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_size  = '0;
    gnt_alp   = 1'b0;
    gnt_bta   = 1'b0;
    stall     = 1'b0;
    rdata_alp = mem_rdata;
    rdata_bta = mem_rdata;

    unique case (cur_state)
      IDLE: begin
        if (mreq_alp) begin
          mem_mreq  = mreq_alp;
          mem_write = write_alp;
          mem_addr  = addr_alp;
          mem_wdata = wdata_alp;
          mem_size  = size_alp;
          gnt_alp   = 1'b1;
          if (mreq_bta) begin
            conflict = 1'b1;
            stall    = 1'b1;
            state_d  = SERVE_BTA;
          end
        end else if (mreq_bta) begin
          mem_mreq  = mreq_bta;
          mem_write = write_bta;
          mem_addr  = addr_bta;
          mem_wdata = wdata_bta;
          mem_size  = size_bta;
          gnt_bta   = 1'b1;
        end
      end
      SERVE_BTA: begin
        // Lane inputs are held stable by the stall, so no new conflict is
        // evaluated here; always hand the port back to IDLE afterwards.
        mem_mreq  = mreq_bta;
        mem_write = write_bta;
        mem_addr  = addr_bta;
        mem_wdata = wdata_bta;
        mem_size  = size_bta;
        gnt_bta   = 1'b1;
        rdata_alp = alp_buf_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      alp_buf_q <= '0;
    end else begin
      state_q <= state_d;
      // Captured for loads and stores alike; for a store it is simply unused.
      if (conflict) alp_buf_q <= mem_rdata;
    end
  end

`ifdef DMEM_ARB_PERF_CNT_EN
  logic [31:0] cnt_q;

  // Only written when it changes, so the count sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (conflict && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign conflict_cnt = cnt_q;
`else
  assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_dmem_dual_arbiter.sv
module tb_dmem_dual_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        mreq_alp, mreq_bta, write_alp, write_bta;
  logic [31:0] addr_alp, addr_bta, wdata_alp, wdata_bta;
  logic [1:0]  size_alp, size_bta;
  logic [31:0] mem_rdata;
  logic        mem_mreq, mem_write;
  logic [31:0] mem_addr, mem_wdata;
  logic [1:0]  mem_size;
  logic [31:0] rdata_alp, rdata_bta;
  logic        gnt_alp, gnt_bta, stall;
  logic [31:0] conflict_cnt;

  always #5 clk = ~clk;

  dmem_dual_arbiter dut (
    .clk(clk), .rst(rst),
    .mreq_alp(mreq_alp), .mreq_bta(mreq_bta),
    .write_alp(write_alp), .write_bta(write_bta),
    .addr_alp(addr_alp), .addr_bta(addr_bta),
    .wdata_alp(wdata_alp), .wdata_bta(wdata_bta),
    .size_alp(size_alp), .size_bta(size_bta),
    .mem_rdata(mem_rdata),
    .mem_mreq(mem_mreq), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_size(mem_size),
    .rdata_alp(rdata_alp), .rdata_bta(rdata_bta),
    .gnt_alp(gnt_alp), .gnt_bta(gnt_bta), .stall(stall),
    .conflict_cnt(conflict_cnt)
  );

  typedef struct packed {
    logic        rst;
    logic        ma, mb, wa, wb;
    logic [31:0] aa, ab, wda, wdb;
    logic [1:0]  sa, sb;
    logic [31:0] rd;
  } in_t;

  typedef struct packed {
    logic        mm, mw;
    logic [31:0] ma, mwd;
    logic [1:0]  ms;
    logic [31:0] ra, rb;
    logic        ga, gb, st;
    logic [31:0] cnt;
  } out_t;

  typedef struct packed {
    in_t  in;
    out_t exp;
  } vec_t;

  vec_t        vecs[$];
  out_t        sb[$];
  int          n_vec  = 0;
  int          n_fail = 0;
  logic [31:0] exp_cnt = '0;

  function automatic vec_t mk(
    input logic r, ma, mb, wa, wb,
    input logic [31:0] aa, ab, wda, wdb,
    input logic [1:0] sa, sb_,
    input logic [31:0] rd,
    input logic omm, omw,
    input logic [31:0] oma, omwd,
    input logic [1:0] oms,
    input logic [31:0] ora, orb,
    input logic oga, ogb, ost);
    vec_t v;
    v.in  = '{r, ma, mb, wa, wb, aa, ab, wda, wdb, sa, sb_, rd};
    v.exp = '{omm, omw, oma, omwd, oms, ora, orb, oga, ogb, ost, 32'd0};
    return v;
  endfunction

  task automatic drive(input in_t i);
    rst = i.rst; mreq_alp = i.ma; mreq_bta = i.mb;
    write_alp = i.wa; write_bta = i.wb;
    addr_alp = i.aa; addr_bta = i.ab;
    wdata_alp = i.wda; wdata_bta = i.wdb;
    size_alp = i.sa; size_bta = i.sb;
    mem_rdata = i.rd;
  endtask

  task automatic apply(input string name, input vec_t v);
    out_t e, a;
    @(posedge clk); #1;
    drive(v.in);
    e     = v.exp;
    e.cnt = exp_cnt;
    sb.push_back(e);
    @(negedge clk);
    a = '{mem_mreq, mem_write, mem_addr, mem_wdata, mem_size,
          rdata_alp, rdata_bta, gnt_alp, gnt_bta, stall, conflict_cnt};
    n_vec++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty, got %h", name, a);
    end else begin
      e = sb.pop_front();
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got mreq=%b wr=%b addr=%h wd=%h sz=%h ra=%h rb=%h ga=%b gb=%b st=%b cnt=%h | want mreq=%b wr=%b addr=%h wd=%h sz=%h ra=%h rb=%h ga=%b gb=%b st=%b cnt=%h",
                 name, a.mm, a.mw, a.ma, a.mwd, a.ms, a.ra, a.rb, a.ga, a.gb, a.st, a.cnt,
                 e.mm, e.mw, e.ma, e.mwd, e.ms, e.ra, e.rb, e.ga, e.gb, e.st, e.cnt);
      end
    end
    // Counter model: reset clears, a conflict cycle counts (saturating).
    if (v.in.rst) exp_cnt = '0;
`ifdef DMEM_ARB_PERF_CNT_EN
    else if (v.exp.st && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
`endif
  endtask

  initial begin
    drive('0);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // Reset held with both requests: IDLE behaviour on live inputs
    vecs.push_back(mk(1,1,1,0,0,'h100,'h200,0,0,2,0,'h9,   1,0,'h100,0,2,'h9,'h9,1,0,1));
    // Idle
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,'h55,          0,0,0,0,0,'h55,'h55,0,0,0));
    // Single alpha load
    vecs.push_back(mk(0,1,0,0,0,'h100,0,0,0,2,0,'hDEADBEEF, 1,0,'h100,0,2,'hDEADBEEF,'hDEADBEEF,1,0,0));
    // Single beta store (state stayed IDLE)
    vecs.push_back(mk(0,0,1,0,1,0,'h40,0,'h1234,0,1,'h77,  1,1,'h40,'h1234,1,'h77,'h77,0,1,0));
    // Dual load
    vecs.push_back(mk(0,1,1,0,0,'h100,'h200,0,0,2,0,'h11,  1,0,'h100,0,2,'h11,'h11,1,0,1));
    vecs.push_back(mk(0,1,1,0,0,'h100,'h200,0,0,2,0,'h22,  1,0,'h200,0,0,'h11,'h22,0,1,0));
    // Alpha store then beta load, same address
    vecs.push_back(mk(0,1,1,1,0,'h300,'h300,'hA5A5A5A5,'hFFFF0000,2,2,'h0,
                      1,1,'h300,'hA5A5A5A5,2,0,0,1,0,1));
    vecs.push_back(mk(0,1,1,1,0,'h300,'h300,'hA5A5A5A5,'hFFFF0000,2,2,'hCAFEF00D,
                      1,0,'h300,'hFFFF0000,2,0,'hCAFEF00D,0,1,0));
    // Back-to-back conflicts
    vecs.push_back(mk(0,1,1,0,0,'h10,'h20,0,0,1,1,'h1,     1,0,'h10,0,1,'h1,'h1,1,0,1));
    vecs.push_back(mk(0,1,1,0,0,'h10,'h20,0,0,1,1,'h2,     1,0,'h20,0,1,'h1,'h2,0,1,0));
    vecs.push_back(mk(0,1,1,0,1,'h30,'h34,0,'h5,3,3,'h3,   1,0,'h30,0,3,'h3,'h3,1,0,1));
    // Reset during SERVE_BTA: beta abandoned, IDLE behaviour
    vecs.push_back(mk(1,1,1,0,1,'h30,'h34,0,'h5,3,3,'h4,   1,0,'h30,0,3,'h4,'h4,1,0,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,'h0,           0,0,0,0,0,0,0,0,0,0));
    // Five idle cycles
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,32'hA0 + i,  0,0,0,0,0,32'hA0 + i,32'hA0 + i,0,0,0));

    foreach (vecs[k]) apply($sformatf("vec%0d", k), vecs[k]);

    // Reset in SERVE_BTA with no requests, then a lone beta load
    apply("rst_serve_c1", mk(0,1,1,0,0,'h500,'h504,0,0,2,2,'h61, 1,0,'h500,0,2,'h61,'h61,1,0,1));
    apply("rst_serve_c2", mk(1,0,0,0,0,0,0,0,0,0,0,'h62,         0,0,0,0,0,'h62,'h62,0,0,0));
    apply("rst_serve_c3", mk(0,0,1,0,0,0,'h508,0,0,0,2,'h63,     1,0,'h508,0,2,'h63,'h63,0,1,0));

`ifdef DMEM_ARB_PERF_CNT_EN
    // Three conflicts from a clean count
    for (int i = 0; i < 3; i++) begin
      apply("cnt3_c1", mk(0,1,1,0,0,'h600,'h604,0,0,2,2,'h70, 1,0,'h600,0,2,'h70,'h70,1,0,1));
      apply("cnt3_c2", mk(0,1,1,0,0,'h600,'h604,0,0,2,2,'h71, 1,0,'h604,0,2,'h70,'h71,0,1,0));
    end
    apply("cnt3_idle", mk(0,0,0,0,0,0,0,0,0,0,0,'h0, 0,0,0,0,0,0,0,0,0,0));
    // Saturation: preload all-ones, one more conflict must not wrap
    @(posedge clk); #2;
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_q;
    exp_cnt = 32'hFFFF_FFFF;
    apply("sat_c1",   mk(0,1,1,0,0,'h700,'h704,0,0,2,2,'h80, 1,0,'h700,0,2,'h80,'h80,1,0,1));
    apply("sat_c2",   mk(0,1,1,0,0,'h700,'h704,0,0,2,2,'h81, 1,0,'h704,0,2,'h80,'h81,0,1,0));
    apply("sat_idle", mk(0,0,0,0,0,0,0,0,0,0,0,'h0, 0,0,0,0,0,0,0,0,0,0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, got running want finished");
    $fatal(1, "timeout");
  end

endmodule
